// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 32-bit ALU between NUM_REQ requesters
//
// Purpose: accepts one request at a time from NUM_REQ requesters over per-requester
// valid/ready handshakes, registers the operands, evaluates them on an internal
// combinational ALU and returns result, flags and requester id over a
// valid/ready response channel.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready is one-hot or zero)
//   req_opcode/a/b    packed per-requester opcode (4b) and operands (32b)
//   rsp_valid/ready   response handshake
//   rsp_id            index of the requester owning the response
//   rsp_result        ALU result
//   rsp_flags         {overflow, negative, zero, carry}
//   busy              high whenever the FSM is not idle
//
// Optional build macro ALU_ARB_STATS_EN adds:
//   op_count          saturating 16-bit count of response handshakes
//   grant_hist        sticky per-requester "has been granted" bits

module alu_arbiter_alu (
    input  logic [3:0]  opcode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;

    logic [32:0] wide;
    logic        ovf;
    logic        cry;

    always_comb begin
        wide   = '0;
        result = '0;
        ovf    = 1'b0;
        cry    = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[31:0];
                cry    = wide[32];
                ovf    = (a[31] == b[31]) && (result[31] != a[31]);
            end
            OP_SUB: begin
                // Bit 32 of the 33-bit difference is the borrow (B > A unsigned).
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[31:0];
                cry    = wide[32];
                ovf    = (a[31] != b[31]) && (result[31] != a[31]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            default: result = '0;
        endcase
        flags = {ovf, result[31], (result == 32'd0), cry};
    end
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_opcode,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic [3:0]           rsp_flags,
    output logic                 busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [NUM_REQ-1:0]   grant_hist
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [3:0]         opr_code;
    logic [31:0]        opr_a;
    logic [31:0]        opr_b;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [3:0]         sel_code;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [31:0]        alu_result;
    logic [3:0]         alu_flags;

    // Round-robin search: first pass covers indices above last_grant, second
    // pass wraps around to 0..last_grant, so the winner is the first valid bit
    // after the previous grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && (i > int'(last_grant)) && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && (i <= int'(last_grant)) && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
    end

    // One-hot AND-OR mux of the granted requester's opcode and operands.
    always_comb begin
        sel_code = '0;
        sel_a    = '0;
        sel_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_code = sel_code | (req_opcode[i*4 +: 4]  & {4{grant_oh[i]}});
            sel_a    = sel_a    | (req_a[i*32 +: 32]     & {32{grant_oh[i]}});
            sel_b    = sel_b    | (req_b[i*32 +: 32]     & {32{grant_oh[i]}});
        end
    end

    // The handshake cycle is the idle cycle itself; reset forces ready low even
    // though the FSM already sits in IDLE.
    assign req_ready = (rst_n && state == IDLE) ? grant_oh : '0;

    alu_arbiter_alu u_alu (
        .opcode (opr_code),
        .a      (opr_a),
        .b      (opr_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LAST_RST;
            opr_code   <= '0;
            opr_a      <= '0;
            opr_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            busy       <= 1'b0;
`ifdef ALU_ARB_STATS_EN
            op_count   <= '0;
            grant_hist <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        opr_code   <= sel_code;
                        opr_a      <= sel_a;
                        opr_b      <= sel_b;
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        state      <= EXEC;
`ifdef ALU_ARB_STATS_EN
                        grant_hist <= grant_hist | grant_oh;
`endif
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef ALU_ARB_STATS_EN
                        if (op_count != 16'hFFFF) begin
                            op_count <= op_count + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (vector table plus response scoreboard)
module tb_alu_arbiter;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] req_opcode;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_result;
    logic [3:0]     rsp_flags;
    logic           busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]    op_count;
    logic [N-1:0]   grant_hist;
`endif

    alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_count   (op_count),
        .grant_hist (grant_hist)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[12];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.flg = flg;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_id), 64'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
                chk("rsp_result", 64'(rsp_result), 64'(mon_e.res));
                chk("rsp_flags", 64'(rsp_flags), 64'(mon_e.flg));
            end
        end
    end

    task automatic drive_req(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_opcode[id*4 +: 4] = op;
        req_a[id*32 +: 32]    = a;
        req_b[id*32 +: 32]    = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic wait_grant();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic do_op(input int id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flg);
        @(posedge clk);
        #1;
        drive_req(id, op, a, b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        wait_grant();
        chk("grant_onehot", 64'(req_ready), 64'(1 << id));
        push(id, res, flg);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1, 4'd1, 32'd5,          32'd7,          32'hFFFF_FFFE, 4'b0101};
        vt[1]  = '{0, 4'd0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000, 4'b1100};
        vt[2]  = '{3, 4'hA, 32'h1234_5678,  32'd9,          32'h0,         4'b0010};
        vt[3]  = '{2, 4'd5, 32'd1,          32'h25,         32'h20,        4'b0000};
        vt[4]  = '{0, 4'd2, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0, 4'b0000};
        vt[5]  = '{1, 4'd3, 32'h8000_0000,  32'd1,          32'h8000_0001, 4'b0100};
        vt[6]  = '{2, 4'd4, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  32'h0,         4'b0010};
        vt[7]  = '{3, 4'd6, 32'h8000_0000,  32'h3F,         32'h1,         4'b0000};
        vt[8]  = '{0, 4'd1, 32'd7,          32'd7,          32'h0,         4'b0010};
        vt[9]  = '{1, 4'd1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 4'b1000};
        vt[10] = '{2, 4'hF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,         4'b0010};
        vt[11] = '{3, 4'd0, 32'h8000_0000,  32'h8000_0000,  32'h0,         4'b1011};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;

        // Reset values, then a single ADD from requester 2 with latency checks.
        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_grant_hist", 64'(grant_hist), 64'd0);
`endif
        @(posedge clk);
        #1;
        drive_req(2, 4'd0, 32'hFFFF_FFFF, 32'd1);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_ready_same_cycle", 64'(req_ready), 64'b0100);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        push(2, 32'h0, 4'b0011);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_exec_no_valid", 64'(rsp_valid), 64'd0);
        chk("t1_exec_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_rsp_valid_2_edges", 64'(rsp_valid), 64'd1);
        wait_drain();

        // Round robin with all four requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) drive_req(i, 4'd0, 32'(i * 100), 32'd7);
        req_valid = 4'b1111;
        for (int g = 0; g < 6; g++) push(g % N, 32'((g % N) * 100 + 7), 4'b0000);
        for (int g = 0; g < 6; g++) begin
            wait_grant();
            chk("rr_grant", 64'(req_ready), 64'(1 << (g % N)));
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();

        // Vector table, one requester at a time.
        for (int v = 0; v < 12; v++) begin
            do_op(vt[v].id, vt[v].op, vt[v].a, vt[v].b, vt[v].res, vt[v].flg);
        end

        // Response back-pressure: outputs held while rsp_ready is low.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        drive_req(3, 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
        req_valid = 4'b1000;
        wait_grant();
        chk("stall_grant", 64'(req_ready), 64'b1000);
        push(3, 32'h0FF0_0FF0, 4'b0000);
        @(posedge clk);
        #1;
        drive_req(0, 4'd0, 32'd2, 32'd3);
        drive_req(1, 4'd2, 32'hFFFF, 32'hF0F0);
        req_valid = 4'b0011;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rsp_valid && n < 20);
        end
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_id", 64'(rsp_id), 64'd3);
            chk("stall_result", 64'(rsp_result), 64'h0FF0_0FF0);
            chk("stall_busy", 64'(busy), 64'd1);
            chk("stall_no_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall_valid_cleared", 64'(rsp_valid), 64'd0);
        chk("stall_next_grant", 64'(req_ready), 64'b0001);
        push(0, 32'd5, 4'b0000);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();

        // Reset during EXEC discards the op and restarts arbitration at 0.
        @(posedge clk);
        #1;
        drive_req(1, 4'd1, 32'd9, 32'd4);
        req_valid = 4'b0010;
        wait_grant();
        chk("abort_grant", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("abort_busy_exec", 64'(busy), 64'd1);
        chk("abort_id_exec", 64'(rsp_id), 64'd1);
        rst_n = 1'b0;
        drive_req(0, 4'd0, 32'd1, 32'd1);
        drive_req(2, 4'd3, 32'd8, 32'd1);
        req_valid = 4'b0101;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_next_grant", 64'(req_ready), 64'b0001);
        push(0, 32'd2, 4'b0000);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain();

`ifdef ALU_ARB_STATS_EN
        do_reset();
        do_op(3, 4'hA, 32'h1234_5678, 32'd9, 32'h0, 4'b0010);
        do_op(2, 4'd5, 32'd1, 32'h25, 32'h20, 4'b0000);
        @(negedge clk);
        chk("stats_op_count", 64'(op_count), 64'd2);
        chk("stats_grant_hist", 64'(grant_hist), 64'b1100);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
